sdr_cmd_fsm: RTL and testbench



---
 rtl/sdr_cmd_fsm_pkg.sv | 48 ++++
 rtl/sdr_cmd_fsm_if.sv | 33 +++
 rtl/sdr_ref_timer.sv | 47 ++++
 rtl/sdr_cmd_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_sdr_cmd_fsm.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sdr_cmd_fsm_pkg.sv
// Shared SDR controller definitions: address field layout and the iState/cState encodings
// that the signal-generation stage decodes.
package sdr_cmd_fsm_pkg;

  localparam int unsigned SDR_BA_WIDTH = 2;
  localparam int unsigned SDR_A_WIDTH  = 13;

  // System address layout: {row, bank, column}
  localparam int unsigned CA_LSB = 0;
  localparam int unsigned CA_MSB = 8;
  localparam int unsigned BA_LSB = 9;
  localparam int unsigned BA_MSB = 10;
  localparam int unsigned RA_LSB = 11;
  localparam int unsigned RA_MSB = 23;

  localparam int unsigned SysAddrW = RA_MSB - CA_LSB + 1;

  typedef logic [SysAddrW-1:0] sys_addr_t;

  localparam logic [3:0] i_NOP   = 4'd0;
  localparam logic [3:0] i_PRE   = 4'd1;
  localparam logic [3:0] i_tRP   = 4'd2;
  localparam logic [3:0] i_AR1   = 4'd3;
  localparam logic [3:0] i_tRFC1 = 4'd4;
  localparam logic [3:0] i_AR2   = 4'd5;
  localparam logic [3:0] i_tRFC2 = 4'd6;
  localparam logic [3:0] i_MRS   = 4'd7;
  localparam logic [3:0] i_tMRD  = 4'd8;
  localparam logic [3:0] i_ready = 4'd9;

  localparam logic [3:0] c_idle   = 4'd0;
  localparam logic [3:0] c_ACTIVE = 4'd1;
  localparam logic [3:0] c_tRCD   = 4'd2;
  localparam logic [3:0] c_READA  = 4'd3;
  localparam logic [3:0] c_cl     = 4'd4;
  localparam logic [3:0] c_rdata  = 4'd5;
  localparam logic [3:0] c_WRITEA = 4'd6;
  localparam logic [3:0] c_wdata  = 4'd7;
  localparam logic [3:0] c_AR     = 4'd8;
  localparam logic [3:0] c_tRFC   = 4'd9;

  // Counter preload for a wait state that follows a 1-cycle command, so that the
  // command-to-command spacing equals n_clk (wait state lasts n_clk-1 cycles).
  function automatic int unsigned wait_load(input int unsigned n_clk);
    return n_clk - 2;
  endfunction

endpackage

// File: rtl/sdr_cmd_fsm_if.sv
// Request/response bus between the AXI4-Lite front end (master) and the command FSM (slave).
interface sdr_cmd_fsm_if;
  import sdr_cmd_fsm_pkg::*;

  logic      sys_req;
  logic      sys_rw;
  sys_addr_t sys_A_in;
  logic      sys_ack;
  sys_addr_t sys_A;
  logic      sys_wr_ready;
  logic      sys_rd_valid;

  modport master (
    output sys_req,
    output sys_rw,
    output sys_A_in,
    input  sys_ack,
    input  sys_A,
    input  sys_wr_ready,
    input  sys_rd_valid
  );

  modport slave (
    input  sys_req,
    input  sys_rw,
    input  sys_A_in,
    output sys_ack,
    output sys_A,
    output sys_wr_ready,
    output sys_rd_valid
  );

endinterface

// File: rtl/sdr_ref_timer.sv
// Auto-refresh interval timer: raises a pending refresh every REF_INTERVAL cycles and flags
// a sticky overrun when a tick arrives before the previous refresh was taken.
module sdr_ref_timer #(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic ref_req_o,
  output logic ref_overrun_o
);

  localparam int unsigned CntW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            ovr_q, ovr_d;
  logic            tick;

  always_comb begin
    tick   = en_i && (cnt_q == CntW'(REF_INTERVAL - 1));
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    ovr_d  = ovr_q | (tick & pend_q);
    // A clear consumes the coincident tick as well, since the requester sees pend_q | tick.
    pend_d = clr_i ? 1'b0 : (pend_q | tick);
  end

  assign ref_req_o     = pend_q | tick;
  assign ref_overrun_o = ovr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule

// File: rtl/sdr_cmd_fsm.sv
// SDRAM controller sequencing stage: power-up init sequence, per-access command FSM with
// post-access guard, request latching and refresh scheduling.
module sdr_cmd_fsm
  import sdr_cmd_fsm_pkg::*;
#(
  parameter int unsigned NUM_CLK_WAIT  = 20000,
  parameter int unsigned NUM_CLK_tRP   = 2,
  parameter int unsigned NUM_CLK_tRFC  = 7,
  parameter int unsigned NUM_CLK_tMRD  = 2,
  parameter int unsigned NUM_CLK_tRCD  = 2,
  parameter int unsigned NUM_CLK_CL    = 2,
  parameter int unsigned NUM_CLK_tWR   = 2,
  parameter int unsigned NUM_CLK_BURST = 4,
  parameter int unsigned REF_INTERVAL  = 780
) (
  input  logic           clk,
  input  logic           reset,
  sdr_cmd_fsm_if.slave   sys,
  output logic           sys_init_done,
  output logic           ref_overrun,
  output logic [3:0]     iState,
  output logic [3:0]     cState
);

  localparam int unsigned IcW = ($clog2(NUM_CLK_WAIT) > 8) ? $clog2(NUM_CLK_WAIT) : 8;

  localparam logic [IcW-1:0] WaitLoad  = IcW'(NUM_CLK_WAIT - 1);
  localparam logic [IcW-1:0] TrpLoadI  = IcW'(wait_load(NUM_CLK_tRP));
  localparam logic [IcW-1:0] TrfcLoadI = IcW'(wait_load(NUM_CLK_tRFC));
  localparam logic [IcW-1:0] TmrdLoadI = IcW'(wait_load(NUM_CLK_tMRD));

  localparam logic [7:0] TrcdLoad  = 8'(wait_load(NUM_CLK_tRCD));
  localparam logic [7:0] ClLoad    = 8'(wait_load(NUM_CLK_CL));
  localparam logic [7:0] RdataLoad = 8'(NUM_CLK_BURST - 1);
  localparam logic [7:0] WdataLoad = 8'(wait_load(NUM_CLK_BURST));
  localparam logic [7:0] TrfcLoad  = 8'(wait_load(NUM_CLK_tRFC));
  // Guard = number of idle cycles before the next decision; the decision cycle is the last one.
  localparam logic [7:0] RdGuard   = 8'(NUM_CLK_tRP - 1);
  localparam logic [7:0] WrGuard   = 8'(NUM_CLK_tWR + NUM_CLK_tRP - 1);

  logic [3:0]     istate_q, istate_d;
  logic [IcW-1:0] icnt_q, icnt_d;
  logic [3:0]     cstate_q, cstate_d;
  logic [7:0]     ccnt_q, ccnt_d;
  logic [7:0]     guard_q, guard_d;
  logic           rw_q, rw_d;
  sys_addr_t      addr_q, addr_d;
  logic           ack_q, ack_d;
  logic           wr_q, rd_q, done_q;
  logic           ref_req, ref_clr;

  sdr_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .clk           (clk),
    .reset         (reset),
    .en_i          (istate_q == i_ready),
    .clr_i         (ref_clr),
    .ref_req_o     (ref_req),
    .ref_overrun_o (ref_overrun)
  );

  always_comb begin
    istate_d = istate_q;
    icnt_d   = icnt_q;
    case (istate_q)
      i_NOP: begin
        if (icnt_q == '0) istate_d = i_PRE;
        else              icnt_d   = icnt_q - 1'b1;
      end
      i_PRE: begin
        istate_d = i_tRP;
        icnt_d   = TrpLoadI;
      end
      i_tRP: begin
        if (icnt_q == '0) istate_d = i_AR1;
        else              icnt_d   = icnt_q - 1'b1;
      end
      i_AR1: begin
        istate_d = i_tRFC1;
        icnt_d   = TrfcLoadI;
      end
      i_tRFC1: begin
        if (icnt_q == '0) istate_d = i_AR2;
        else              icnt_d   = icnt_q - 1'b1;
      end
      i_AR2: begin
        istate_d = i_tRFC2;
        icnt_d   = TrfcLoadI;
      end
      i_tRFC2: begin
        if (icnt_q == '0) istate_d = i_MRS;
        else              icnt_d   = icnt_q - 1'b1;
      end
      i_MRS: begin
        istate_d = i_tMRD;
        icnt_d   = TmrdLoadI;
      end
      i_tMRD: begin
        if (icnt_q == '0) istate_d = i_ready;
        else              icnt_d   = icnt_q - 1'b1;
      end
      i_ready: istate_d = i_ready;
      default: begin
        istate_d = i_NOP;
        icnt_d   = WaitLoad;
      end
    endcase
  end

  always_comb begin
    cstate_d = cstate_q;
    ccnt_d   = ccnt_q;
    guard_d  = guard_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    ack_d    = 1'b0;
    ref_clr  = 1'b0;
    if (istate_q == i_ready) begin
      case (cstate_q)
        c_idle: begin
          if (guard_q != '0) begin
            guard_d = guard_q - 1'b1;
          end else if (ref_req) begin
            cstate_d = c_AR;
            ref_clr  = 1'b1;
          end else if (sys.sys_req) begin
            cstate_d = c_ACTIVE;
            addr_d   = sys.sys_A_in;
            rw_d     = sys.sys_rw;
            ack_d    = 1'b1;
          end
        end
        c_ACTIVE: begin
          cstate_d = c_tRCD;
          ccnt_d   = TrcdLoad;
        end
        c_tRCD: begin
          if (ccnt_q == '0) cstate_d = rw_q ? c_READA : c_WRITEA;
          else              ccnt_d   = ccnt_q - 1'b1;
        end
        c_READA: begin
          cstate_d = c_cl;
          ccnt_d   = ClLoad;
        end
        c_cl: begin
          if (ccnt_q == '0) begin
            cstate_d = c_rdata;
            ccnt_d   = RdataLoad;
          end else begin
            ccnt_d = ccnt_q - 1'b1;
          end
        end
        c_rdata: begin
          if (ccnt_q == '0) begin
            cstate_d = c_idle;
            guard_d  = RdGuard;
          end else begin
            ccnt_d = ccnt_q - 1'b1;
          end
        end
        c_WRITEA: begin
          cstate_d = c_wdata;
          ccnt_d   = WdataLoad;
        end
        c_wdata: begin
          if (ccnt_q == '0) begin
            cstate_d = c_idle;
            guard_d  = WrGuard;
          end else begin
            ccnt_d = ccnt_q - 1'b1;
          end
        end
        c_AR: begin
          cstate_d = c_tRFC;
          ccnt_d   = TrfcLoad;
        end
        c_tRFC: begin
          if (ccnt_q == '0) begin
            cstate_d = c_idle;
            guard_d  = '0;
          end else begin
            ccnt_d = ccnt_q - 1'b1;
          end
        end
        default: begin
          cstate_d = c_idle;
          guard_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      istate_q <= i_NOP;
      icnt_q   <= WaitLoad;
      cstate_q <= c_idle;
      ccnt_q   <= '0;
      guard_q  <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      ack_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      istate_q <= istate_d;
      icnt_q   <= icnt_d;
      cstate_q <= cstate_d;
      ccnt_q   <= ccnt_d;
      guard_q  <= guard_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
      wr_q     <= (cstate_d == c_WRITEA) || (cstate_d == c_wdata);
      rd_q     <= (cstate_d == c_rdata);
      done_q   <= (istate_d == i_ready);
    end
  end

  assign sys.sys_ack      = ack_q;
  assign sys.sys_A        = addr_q;
  assign sys.sys_wr_ready = wr_q;
  assign sys.sys_rd_valid = rd_q;
  assign sys_init_done    = done_q;
  assign iState           = istate_q;
  assign cState           = cstate_q;

endmodule

// File: tb/tb_sdr_cmd_fsm.sv
// Directed bench for sdr_cmd_fsm: init sequence, read/write timing, refresh priority,
// refresh overrun (second instance with a tiny interval) and mid-access reset.
module tb_sdr_cmd_fsm;
  import sdr_cmd_fsm_pkg::*;

  logic clk;
  logic reset;
  logic done1, ovr1, done2, ovr2;
  logic [3:0] ist1, cst1, ist2, cst2;
  int n_checks = 0;
  int n_fail   = 0;
  int cur_k    = 0;

  sdr_cmd_fsm_if bus1 ();
  sdr_cmd_fsm_if bus2 ();

  sdr_cmd_fsm #(
    .NUM_CLK_WAIT (10),
    .REF_INTERVAL (60)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sys           (bus1),
    .sys_init_done (done1),
    .ref_overrun   (ovr1),
    .iState        (ist1),
    .cState        (cst1)
  );

  // Interval far shorter than an access, so refresh ticks stack up and overrun.
  sdr_cmd_fsm #(
    .NUM_CLK_WAIT (10),
    .REF_INTERVAL (2)
  ) dut2 (
    .clk           (clk),
    .reset         (reset),
    .sys           (bus2),
    .sys_init_done (done2),
    .ref_overrun   (ovr2),
    .iState        (ist2),
    .cState        (cst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_istate(input int k);
    if (k <= 9)  return 4'd0;
    if (k == 10) return 4'd1;
    if (k == 11) return 4'd2;
    if (k == 12) return 4'd3;
    if (k <= 18) return 4'd4;
    if (k == 19) return 4'd5;
    if (k <= 25) return 4'd6;
    if (k == 26) return 4'd7;
    if (k == 27) return 4'd8;
    return 4'd9;
  endfunction

  function automatic logic [3:0] exp_cstate(input int k);
    if (k <= 28)  return 4'd0;
    if (k == 29)  return 4'd1;
    if (k == 30)  return 4'd2;
    if (k == 31)  return 4'd3;
    if (k == 32)  return 4'd4;
    if (k <= 36)  return 4'd5;
    if (k <= 38)  return 4'd0;
    if (k == 39)  return 4'd1;
    if (k == 40)  return 4'd2;
    if (k == 41)  return 4'd6;
    if (k <= 44)  return 4'd7;
    if (k <= 48)  return 4'd0;
    if (k == 49)  return 4'd1;
    if (k == 50)  return 4'd2;
    if (k == 51)  return 4'd3;
    if (k == 52)  return 4'd4;
    if (k <= 56)  return 4'd5;
    if (k <= 87)  return 4'd0;
    if (k == 88)  return 4'd8;
    if (k <= 94)  return 4'd9;
    if (k == 95)  return 4'd0;
    if (k == 96)  return 4'd1;
    if (k == 97)  return 4'd2;
    if (k == 98)  return 4'd3;
    if (k == 99)  return 4'd4;
    if (k <= 103) return 4'd5;
    if (k <= 105) return 4'd0;
    if (k == 106) return 4'd1;
    if (k == 107) return 4'd2;
    if (k == 108) return 4'd3;
    if (k == 109) return 4'd4;
    return 4'd5;
  endfunction

  initial begin
    logic [3:0] ec;
    reset         = 1'b1;
    bus1.sys_req  = 1'b0;
    bus1.sys_rw   = 1'b0;
    bus1.sys_A_in = '0;
    bus2.sys_req  = 1'b1;
    bus2.sys_rw   = 1'b1;
    bus2.sys_A_in = 24'h00F0F0;
    repeat (3) @(posedge clk);
    #1;
    reset         = 1'b0;
    bus1.sys_req  = 1'b1;
    bus1.sys_rw   = 1'b1;
    bus1.sys_A_in = 24'h001234;

    for (int k = 0; k <= 110; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      cur_k = k;
      ec = exp_cstate(k);
      check_eq("istate", 32'(ist1), 32'(exp_istate(k)));
      check_eq("cstate", 32'(cst1), 32'(ec));
      check_eq("init_done", 32'(done1), 32'(exp_istate(k) == 4'd9));
      check_eq("ack", 32'(bus1.sys_ack), 32'(ec == 4'd1));
      check_eq("rd_valid", 32'(bus1.sys_rd_valid), 32'(ec == 4'd5));
      check_eq("wr_ready", 32'(bus1.sys_wr_ready), 32'((ec == 4'd6) || (ec == 4'd7)));

      if (k == 29) check_eq("addr_rd1", 32'(bus1.sys_A), 32'h001234);
      if (k == 38) check_eq("addr_hold", 32'(bus1.sys_A), 32'h001234);
      if (k == 39) check_eq("addr_wr", 32'(bus1.sys_A), 32'h0ABCDE);
      if (k == 49) check_eq("addr_rd2", 32'(bus1.sys_A), 32'h000555);
      if (k == 96) check_eq("addr_ref", 32'(bus1.sys_A), 32'h002222);
      if (k == 106) check_eq("addr_rd4", 32'(bus1.sys_A), 32'h003333);
      if (k == 105) check_eq("ovr1_clear", 32'(ovr1), 32'h0);
      if (k == 20) check_eq("ovr2_init", 32'(ovr2), 32'h0);
      if (k == 40) check_eq("ovr2_set", 32'(ovr2), 32'h1);
      if (k == 100) check_eq("ovr2_sticky", 32'(ovr2), 32'h1);

      case (k)
        29, 39, 49, 96, 106: bus1.sys_req = 1'b0;
        36: begin
          bus1.sys_req  = 1'b1;
          bus1.sys_rw   = 1'b0;
          bus1.sys_A_in = 24'h0ABCDE;
        end
        44: begin
          bus1.sys_req  = 1'b1;
          bus1.sys_rw   = 1'b1;
          bus1.sys_A_in = 24'h000555;
        end
        87: begin
          bus1.sys_req  = 1'b1;
          bus1.sys_rw   = 1'b1;
          bus1.sys_A_in = 24'h002222;
        end
        104: begin
          bus1.sys_req  = 1'b1;
          bus1.sys_rw   = 1'b1;
          bus1.sys_A_in = 24'h003333;
        end
        110: reset = 1'b1;
        default: ;
      endcase
    end

    @(posedge clk);
    #1;
    cur_k = 111;
    check_eq("rst_istate", 32'(ist1), 32'h0);
    check_eq("rst_cstate", 32'(cst1), 32'h0);
    check_eq("rst_ack", 32'(bus1.sys_ack), 32'h0);
    check_eq("rst_addr", 32'(bus1.sys_A), 32'h0);
    check_eq("rst_wr", 32'(bus1.sys_wr_ready), 32'h0);
    check_eq("rst_rd", 32'(bus1.sys_rd_valid), 32'h0);
    check_eq("rst_done", 32'(done1), 32'h0);
    check_eq("rst_ovr1", 32'(ovr1), 32'h0);
    check_eq("rst_ovr2", 32'(ovr2), 32'h0);
    reset = 1'b0;

    for (int j = 1; j <= 11; j++) begin
      @(posedge clk);
      #1;
      cur_k = 111 + j;
      check_eq("reinit_istate", 32'(ist1), 32'(exp_istate(j)));
      check_eq("reinit_cstate", 32'(cst1), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
